rd_ptr_flag_gen: RTL and testbench
==================================

Name: rd_ptr_flag_gen

Overview:
Read-domain pointer and status generator for the asynchronous FIFO. It is the parametrised successor of the basic read-pointer block and adds four things: an internal multi-stage write-pointer synchroniser, a registered occupancy count, a programmable almost-empty flag, and a sticky underflow flag. It sits between the write-domain gray pointer and the dual-port RAM read address, and reports read-side status to the consumer.

Parameters:
ADDR_SIZE, 4, RAM address width; FIFO depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
SYNC_STAGES, 2, number of rd_clk flops in the write-pointer synchroniser; legal values >= 2.

Ports:
rd_clk  input  1  read-domain clock.
rd_rst  input  1  asynchronous, active-high reset.
rd_ena  input  1  read request; pops one word when rd_empty=0.
wrt_ptr_gray  input  ADDR_SIZE+1  write pointer in gray code, asynchronous to rd_clk.
ae_thresh  input  ADDR_SIZE+1  almost-empty threshold; quasi-static.
underflow_clr  input  1  clears rd_underflow.
rd_addr  output  ADDR_SIZE  RAM read address.
rd_ptr  output  ADDR_SIZE+1  registered gray read pointer, sent to the write domain.
rd_empty  output  1  FIFO empty.
rd_almost_empty  output  1  occupancy <= ae_thresh.
rd_level  output  ADDR_SIZE+1  read-side occupancy, 0..2**ADDR_SIZE.
rd_underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Synchroniser: a chain of SYNC_STAGES flops clocked on rd_clk carries wrt_ptr_gray; the last stage is sync_wptr.
- wbin = gray-to-binary(sync_wptr), combinational.
- rd_inc = rd_ena & ~rd_empty.
- rd_bin_nxt = rd_bin + rd_inc, computed modulo 2**(ADDR_SIZE+1).
- rd_gray_nxt = (rd_bin_nxt >> 1) ^ rd_bin_nxt.
- Registers updated every rd_clk edge: rd_bin <= rd_bin_nxt; rd_ptr <= rd_gray_nxt.
- rd_addr = rd_bin[ADDR_SIZE-1:0]. The word at rd_addr is the current head; the pop advances the address one cycle later.
- level_nxt = (wbin - rd_bin_nxt) modulo 2**(ADDR_SIZE+1).
- Flag registers: rd_level <= level_nxt; rd_empty <= (rd_gray_nxt == sync_wptr); rd_almost_empty <= (level_nxt <= ae_thresh).
- Invariant: rd_empty=1 exactly when rd_level=0, on every cycle.
- Underflow: rd_ena & rd_empty sets rd_underflow; underflow_clr clears it; set wins when both occur in the same cycle. A read while empty never moves the pointer.
- Reset (asynchronous, takes effect immediately):
  - rd_bin=0, rd_ptr=0, rd_addr=0.
  - all synchroniser stages=0.
  - rd_empty=1, rd_almost_empty=1, rd_level=0, rd_underflow=0.
- Reset mid-operation: every register returns to its reset value regardless of any read in flight. The write domain is reset concurrently; this is a system requirement.
- Latency:
  - A write-pointer change is visible on rd_level/rd_empty SYNC_STAGES+1 rd_clk edges later.
  - A pop updates rd_ptr/rd_addr/rd_level/flags on the same edge.
- Wrap: rd_bin wraps from 2**(ADDR_SIZE+1)-1 to 0. The MSB distinguishes laps. A full FIFO gives rd_level = 2**ADDR_SIZE.
- Simultaneous pop and synchronised write advance: rd_level is unchanged.
- ae_thresh >= 2**ADDR_SIZE: rd_almost_empty is held at 1. ae_thresh = 0: rd_almost_empty equals rd_empty.
- Changing ae_thresh takes effect on the next edge; no glitch filtering.
- Elaboration error if ADDR_SIZE < 1 or SYNC_STAGES < 2.
- wrt_ptr_gray must change by at most one bit per write-clock cycle; this is guaranteed by the gray encoding upstream.

Test Plan:
(All scenarios use ADDR_SIZE=4, SYNC_STAGES=2.)
1. Reset: pulse rd_rst between clock edges -> immediately rd_empty=1, rd_almost_empty=1, rd_level=0, rd_ptr=5'b00000, rd_addr=0, rd_underflow=0.
2. Sync latency and flags: ae_thresh=2, hold wrt_ptr_gray=5'b00010 (bin 3).
   - 3rd rd_clk edge -> rd_empty=0, rd_level=3, rd_almost_empty=0; no change before that edge.
   - One pop -> rd_level=2, rd_almost_empty=1, rd_addr=1, rd_ptr=5'b00001.
3. Underflow while empty: rd_ena=1 for 1 cycle.
   - rd_ptr unchanged, rd_underflow=1, and it stays 1.
   - underflow_clr=1 alone -> 0.
   - rd_ena and underflow_clr together while empty -> 1.
4. Full and wrap: wrt_ptr_gray=5'b11000 (bin 16) -> rd_level=16.
   - 16 pops -> rd_empty=1, rd_ptr=5'b11000, rd_addr=0.
   - Advance the write pointer another 16 and pop 16 -> rd_ptr=5'b00000, rd_empty=1.
5. Concurrent activity: steady pops every cycle while the write pointer advances by 1 per cycle -> rd_level constant, rd_empty never asserts, rd_empty==(rd_level==0) checked every cycle.
6. Reset mid-burst: assert rd_rst asynchronously at level 7 with rd_ena=1 -> all outputs at reset values at once. After release and wrt_ptr_gray reset to 0, rd_empty stays 1.

Source files
------------

// File: rtl/rd_ptr_flag_gen_if.sv
// Read-side FIFO status bus between the read pointer generator and its consumer.
//   slave  : pointer generator side (takes requests, drives pointer/status)
//   master : consumer side (drives requests/threshold, observes pointer/status)
// Signals:
//   rd_ena          read request
//   wrt_ptr_gray    write pointer in gray code (write clock domain)
//   ae_thresh       almost-empty threshold, quasi-static
//   underflow_clr   clears the sticky underflow flag
//   rd_addr         RAM read address
//   rd_ptr          gray read pointer toward the write domain
//   rd_empty        FIFO empty
//   rd_almost_empty occupancy <= ae_thresh
//   rd_level        read-side occupancy
//   rd_underflow    sticky read-while-empty flag
interface rd_ptr_flag_gen_if #(
   parameter int ADDR_SIZE = 4
);
   logic                 rd_ena;
   logic [ADDR_SIZE:0]   wrt_ptr_gray;
   logic [ADDR_SIZE:0]   ae_thresh;
   logic                 underflow_clr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic [ADDR_SIZE:0]   rd_ptr;
   logic                 rd_empty;
   logic                 rd_almost_empty;
   logic [ADDR_SIZE:0]   rd_level;
   logic                 rd_underflow;

   modport slave (
      input  rd_ena, wrt_ptr_gray, ae_thresh, underflow_clr,
      output rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level, rd_underflow
   );

   modport master (
      output rd_ena, wrt_ptr_gray, ae_thresh, underflow_clr,
      input  rd_addr, rd_ptr, rd_empty, rd_almost_empty, rd_level, rd_underflow
   );
endinterface

// File: rtl/rd_ptr_flag_gen.sv
// Read-domain pointer and status generator for an asynchronous FIFO.
// Synchronises the gray write pointer into rd_clk, advances the read pointer
// on accepted pops and registers empty / almost-empty / occupancy / underflow.
// Ports:
//   rd_clk  read-domain clock
//   rd_rst  asynchronous active-high reset
//   bus     rd_ptr_flag_gen_if.slave: read request, write pointer, threshold,
//           underflow clear in; RAM address, gray read pointer, flags out
module rd_ptr_flag_gen #(
   parameter int ADDR_SIZE   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             rd_clk,
   input  logic             rd_rst,
   rd_ptr_flag_gen_if.slave bus
);

   generate
      if (ADDR_SIZE < 1 || SYNC_STAGES < 2) begin : g_bad_params
         $error("rd_ptr_flag_gen: ADDR_SIZE must be >= 1 and SYNC_STAGES >= 2");
      end
   endgenerate

   logic [ADDR_SIZE:0] sync_q [SYNC_STAGES];
   logic [ADDR_SIZE:0] sync_wptr;
   logic [ADDR_SIZE:0] wbin;

   logic [ADDR_SIZE:0] rd_bin;
   logic [ADDR_SIZE:0] rd_bin_nxt;
   logic [ADDR_SIZE:0] rd_gray_nxt;
   logic [ADDR_SIZE:0] level_nxt;
   logic               rd_inc;

   logic [ADDR_SIZE:0] rd_ptr_q;
   logic [ADDR_SIZE:0] rd_level_q;
   logic               rd_empty_q;
   logic               rd_almost_empty_q;
   logic               rd_underflow_q;

   // Write-pointer synchroniser chain.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.wrt_ptr_gray;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_wptr = sync_q[SYNC_STAGES-1];

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
   always_comb begin
      wbin = '0;
      for (int unsigned i = 0; i <= ADDR_SIZE; i++) begin
         wbin[i] = ^(sync_wptr >> i);
      end
   end

   always_comb begin
      rd_inc      = bus.rd_ena & ~rd_empty_q;
      rd_bin_nxt  = rd_bin + {{ADDR_SIZE{1'b0}}, rd_inc};
      rd_gray_nxt = (rd_bin_nxt >> 1) ^ rd_bin_nxt;
      level_nxt   = wbin - rd_bin_nxt;
   end

   // Flags are computed from the post-pop pointer so a pop and its status
   // change land on the same edge; empty compares gray codes directly.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         rd_bin            <= '0;
         rd_ptr_q          <= '0;
         rd_level_q        <= '0;
         rd_empty_q        <= 1'b1;
         rd_almost_empty_q <= 1'b1;
         rd_underflow_q    <= 1'b0;
      end else begin
         rd_bin            <= rd_bin_nxt;
         rd_ptr_q          <= rd_gray_nxt;
         rd_level_q        <= level_nxt;
         rd_empty_q        <= (rd_gray_nxt == sync_wptr);
         rd_almost_empty_q <= (level_nxt <= bus.ae_thresh);
         // Set has priority over clear.
         if (bus.rd_ena & rd_empty_q) begin
            rd_underflow_q <= 1'b1;
         end else if (bus.underflow_clr) begin
            rd_underflow_q <= 1'b0;
         end
      end
   end

   assign bus.rd_addr         = rd_bin[ADDR_SIZE-1:0];
   assign bus.rd_ptr          = rd_ptr_q;
   assign bus.rd_level        = rd_level_q;
   assign bus.rd_empty        = rd_empty_q;
   assign bus.rd_almost_empty = rd_almost_empty_q;
   assign bus.rd_underflow    = rd_underflow_q;

endmodule

// File: tb/tb_rd_ptr_flag_gen.sv
module tb_rd_ptr_flag_gen;

   localparam int AS = 4;

   logic rd_clk;
   logic rd_rst;

   rd_ptr_flag_gen_if #(.ADDR_SIZE(AS)) bus ();

   rd_ptr_flag_gen #(.ADDR_SIZE(AS), .SYNC_STAGES(2)) dut (
      .rd_clk (rd_clk),
      .rd_rst (rd_rst),
      .bus    (bus)
   );

   initial begin
      rd_clk = 1'b0;
      forever #5 rd_clk = ~rd_clk;
   end

   typedef struct {
      logic       ena;
      logic       clr;
      logic [4:0] wg;
      logic [4:0] th;
      logic       e_empty;
      logic       e_ae;
      logic [4:0] e_level;
      logic [4:0] e_ptr;
      logic [3:0] e_addr;
      logic       e_uf;
   } vec_t;

   vec_t tbl [18];
   int checks = 0;
   int errors = 0;
   logic [4:0] w_bin;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   function automatic logic [4:0] to_gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, " empty"},    32'(bus.rd_empty),        32'd1);
      chk({tag, " ae"},       32'(bus.rd_almost_empty), 32'd1);
      chk({tag, " level"},    32'(bus.rd_level),        32'd0);
      chk({tag, " ptr"},      32'(bus.rd_ptr),          32'd0);
      chk({tag, " addr"},     32'(bus.rd_addr),         32'd0);
      chk({tag, " uf"},       32'(bus.rd_underflow),    32'd0);
   endtask

   task automatic chk_inv(input string tag);
      chk({tag, " empty==(level==0)"}, 32'(bus.rd_empty), 32'(bus.rd_level == 5'd0));
   endtask

   initial begin
      //            ena clr wg        th       emp ae lvl    ptr       addr uf
      tbl[0]  = '{1'b0,1'b0,5'b00010,5'd2,  1'b1,1'b1,5'd0,5'b00000,4'd0,1'b0};
      tbl[1]  = '{1'b0,1'b0,5'b00010,5'd2,  1'b1,1'b1,5'd0,5'b00000,4'd0,1'b0};
      tbl[2]  = '{1'b0,1'b0,5'b00010,5'd2,  1'b0,1'b0,5'd3,5'b00000,4'd0,1'b0};
      tbl[3]  = '{1'b1,1'b0,5'b00010,5'd2,  1'b0,1'b1,5'd2,5'b00001,4'd1,1'b0};
      tbl[4]  = '{1'b1,1'b0,5'b00010,5'd2,  1'b0,1'b1,5'd1,5'b00011,4'd2,1'b0};
      tbl[5]  = '{1'b1,1'b0,5'b00010,5'd2,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b0};
      tbl[6]  = '{1'b1,1'b0,5'b00010,5'd2,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b1};
      tbl[7]  = '{1'b0,1'b0,5'b00010,5'd2,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b1};
      tbl[8]  = '{1'b0,1'b1,5'b00010,5'd2,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b0};
      tbl[9]  = '{1'b1,1'b1,5'b00010,5'd2,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b1};
      tbl[10] = '{1'b0,1'b1,5'b00010,5'd2,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b0};
      tbl[11] = '{1'b0,1'b0,5'b00010,5'd0,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b0};
      tbl[12] = '{1'b0,1'b0,5'b00110,5'd0,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b0};
      tbl[13] = '{1'b0,1'b0,5'b00110,5'd0,  1'b1,1'b1,5'd0,5'b00010,4'd3,1'b0};
      tbl[14] = '{1'b0,1'b0,5'b00110,5'd0,  1'b0,1'b0,5'd1,5'b00010,4'd3,1'b0};
      tbl[15] = '{1'b0,1'b0,5'b00110,5'd16, 1'b0,1'b1,5'd1,5'b00010,4'd3,1'b0};
      tbl[16] = '{1'b0,1'b0,5'b00110,5'd1,  1'b0,1'b1,5'd1,5'b00010,4'd3,1'b0};
      tbl[17] = '{1'b1,1'b0,5'b00110,5'd0,  1'b1,1'b1,5'd0,5'b00110,4'd4,1'b0};

      rd_rst            = 1'b0;
      bus.rd_ena        = 1'b0;
      bus.underflow_clr = 1'b0;
      bus.wrt_ptr_gray  = '0;
      bus.ae_thresh     = 5'd2;

      // Reset pulsed between edges takes effect immediately.
      #2 rd_rst = 1'b1;
      #1 chk_reset("reset");
      #5 rd_rst = 1'b0;

      // Sync latency, pop, underflow and threshold vectors.
      for (int i = 0; i < 18; i++) begin
         bus.rd_ena        = tbl[i].ena;
         bus.underflow_clr = tbl[i].clr;
         bus.wrt_ptr_gray  = tbl[i].wg;
         bus.ae_thresh     = tbl[i].th;
         tick();
         chk($sformatf("v%0d empty", i), 32'(bus.rd_empty),        32'(tbl[i].e_empty));
         chk($sformatf("v%0d ae", i),    32'(bus.rd_almost_empty), 32'(tbl[i].e_ae));
         chk($sformatf("v%0d level", i), 32'(bus.rd_level),        32'(tbl[i].e_level));
         chk($sformatf("v%0d ptr", i),   32'(bus.rd_ptr),          32'(tbl[i].e_ptr));
         chk($sformatf("v%0d addr", i),  32'(bus.rd_addr),         32'(tbl[i].e_addr));
         chk($sformatf("v%0d uf", i),    32'(bus.rd_underflow),    32'(tbl[i].e_uf));
      end
      bus.rd_ena        = 1'b0;
      bus.underflow_clr = 1'b0;
      bus.ae_thresh     = 5'd2;

      // Mid-operation reset from a nonzero pointer.
      #2 rd_rst = 1'b1;
      bus.wrt_ptr_gray = '0;
      #1 chk_reset("reset2");
      @(negedge rd_clk);
      rd_rst = 1'b0;

      // Full FIFO, drain, then a second lap to wrap the pointer.
      w_bin = 5'd16;
      bus.wrt_ptr_gray = to_gray(w_bin);
      repeat (3) tick();
      chk("full level", 32'(bus.rd_level), 32'd16);
      chk("full empty", 32'(bus.rd_empty), 32'd0);
      chk("full ae",    32'(bus.rd_almost_empty), 32'd0);
      bus.rd_ena = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("drain%0d level", k), 32'(bus.rd_level), 32'(16 - k));
         chk_inv($sformatf("drain%0d", k));
      end
      bus.rd_ena = 1'b0;
      chk("lap1 empty", 32'(bus.rd_empty), 32'd1);
      chk("lap1 ptr",   32'(bus.rd_ptr),   32'b11000);
      chk("lap1 addr",  32'(bus.rd_addr),  32'd0);
      for (int k = 0; k < 16; k++) begin
         w_bin = w_bin + 5'd1;
         bus.wrt_ptr_gray = to_gray(w_bin);
         tick();
      end
      repeat (3) tick();
      chk("lap2 level", 32'(bus.rd_level), 32'd16);
      bus.rd_ena = 1'b1;
      repeat (16) tick();
      bus.rd_ena = 1'b0;
      chk("lap2 empty", 32'(bus.rd_empty), 32'd1);
      chk("lap2 ptr",   32'(bus.rd_ptr),   32'b00000);
      chk("lap2 addr",  32'(bus.rd_addr),  32'd0);
      chk("lap2 level0", 32'(bus.rd_level), 32'd0);

      // Concurrent pops and writes: writer leads by two cycles so the
      // synchronised write advance and the pop coincide from the first pop.
      for (int k = 0; k < 4; k++) begin
         w_bin = w_bin + 5'd1;
         bus.wrt_ptr_gray = to_gray(w_bin);
         tick();
      end
      repeat (3) tick();
      chk("conc start level", 32'(bus.rd_level), 32'd4);
      for (int k = 0; k < 20; k++) begin
         w_bin = w_bin + 5'd1;
         bus.wrt_ptr_gray = to_gray(w_bin);
         bus.rd_ena = (k >= 2);
         tick();
         chk($sformatf("conc%0d level", k), 32'(bus.rd_level), 32'd4);
         chk($sformatf("conc%0d empty", k), 32'(bus.rd_empty), 32'd0);
         chk_inv($sformatf("conc%0d", k));
      end
      bus.rd_ena = 1'b0;

      // Bring occupancy to 7, then reset asynchronously with a pop pending.
      w_bin = w_bin + 5'd1;
      bus.wrt_ptr_gray = to_gray(w_bin);
      repeat (3) tick();
      chk("pre-reset level", 32'(bus.rd_level), 32'd7);
      bus.rd_ena = 1'b1;
      #2 rd_rst = 1'b1;
      #1 chk_reset("burst reset");
      bus.rd_ena = 1'b0;
      bus.wrt_ptr_gray = '0;
      @(negedge rd_clk);
      rd_rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("post-reset%0d empty", k), 32'(bus.rd_empty), 32'd1);
         chk($sformatf("post-reset%0d level", k), 32'(bus.rd_level), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
